// File: rtl/inventory_tracker.sv
// inventory_tracker
// Multi-slot player inventory: one saturating counter per item, a global
// capacity limit across all items, sticky or consumable behaviour per slot,
// and registered use-success / pickup-reject pulses for the win/lose logic.
module inventory_tracker #(
  parameter int                 N_ITEMS         = 4,
  parameter int                 CNT_W           = 3,
  parameter int                 CAPACITY        = 8,
  parameter logic [N_ITEMS-1:0] CONSUMABLE_MASK = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_ITEMS-1:0]                pickup,
  input  logic [N_ITEMS-1:0]                use_req,
  input  logic                              drop_all,
  output logic [N_ITEMS-1:0]                have,
  output logic [N_ITEMS*CNT_W-1:0]          count,
  output logic [$clog2(CAPACITY+1)-1:0]     total,
  output logic                              full,
  output logic [N_ITEMS-1:0]                use_ok,
  output logic                              reject
);

  localparam int                 TOT_W   = $clog2(CAPACITY + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0]   CAP_V   = TOT_W'(CAPACITY);

  // Per-item counters: the only architectural state besides the pulses.
  logic [CNT_W-1:0] cnt     [N_ITEMS];
  logic [CNT_W-1:0] cnt_nxt [N_ITEMS];

  logic [N_ITEMS-1:0] use_ok_nxt;
  logic               reject_nxt;

  // Running total consumed by pickups in ascending index order this cycle.
  logic [TOT_W-1:0]   pick_rt;

  // Counters never wrap; both helpers hold at their rail.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    if (v == '0) begin
      return v;
    end
    return v - CNT_W'(1);
  endfunction

  // Status views derived purely from the current counters.
  always_comb begin
    have  = '0;
    count = '0;
    total = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      have[i]                  = (cnt[i] != '0);
      count[i*CNT_W +: CNT_W]  = cnt[i];
      total                    = total + TOT_W'(cnt[i]);
    end
    full = (total == CAP_V);
  end

  // Next-state: pickups are granted lowest index first against a running
  // total that starts at the cycle-start total (same-cycle consumption is not
  // credited); use success always looks at the old count, so a consumable
  // picked up and used in one cycle nets to zero change.
  always_comb begin
    pick_rt    = total;
    use_ok_nxt = '0;
    reject_nxt = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (drop_all) begin
        cnt_nxt[i] = '0;
      end else begin
        if (use_req[i] && (cnt[i] != '0)) begin
          use_ok_nxt[i] = 1'b1;
        end
        if (pickup[i]) begin
          if ((cnt[i] != CNT_MAX) && (pick_rt < CAP_V)) begin
            cnt_nxt[i] = sat_inc(cnt[i]);
            pick_rt    = pick_rt + TOT_W'(1);
          end else begin
            reject_nxt = 1'b1;
          end
        end
        if (use_req[i] && (cnt[i] != '0) && CONSUMABLE_MASK[i]) begin
          cnt_nxt[i] = sat_dec(cnt_nxt[i]);
        end
      end
    end
  end

  // State register: reset clears counters and pulses, otherwise load next.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        cnt[i] <= '0;
      end
      use_ok <= '0;
      reject <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      use_ok <= use_ok_nxt;
      reject <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_inventory_tracker.sv
// Bench for inventory_tracker: directed vector table covering the listed
// scenarios, followed by randomized traffic checked against an integer model.
module tb_inventory_tracker;

  localparam int N     = 4;
  localparam int CW    = 3;
  localparam int CAP   = 8;
  localparam int TW    = $clog2(CAP + 1);
  localparam int MAXC  = (1 << CW) - 1;
  localparam logic [N-1:0] MASK = 4'b0010;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pickup;
  logic [N-1:0]    use_req;
  logic            drop_all;
  logic [N-1:0]    have;
  logic [N*CW-1:0] count;
  logic [TW-1:0]   total;
  logic            full;
  logic [N-1:0]    use_ok;
  logic            reject;

  inventory_tracker #(
    .N_ITEMS(N), .CNT_W(CW), .CAPACITY(CAP), .CONSUMABLE_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .pickup(pickup), .use_req(use_req),
    .drop_all(drop_all), .have(have), .count(count), .total(total),
    .full(full), .use_ok(use_ok), .reject(reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic       drop;
    logic [3:0] pk;
    logic [3:0] us;
    int         c [4];
    logic [3:0] uok;
    logic       rej;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic drop, input logic [3:0] pk, input logic [3:0] us,
                     input int c0, input int c1, input int c2, input int c3,
                     input logic [3:0] uok, input logic rej);
    vec_t v;
    v.rst = rst; v.drop = drop; v.pk = pk; v.us = us;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.uok = uok; v.rej = rej;
    vecs.push_back(v);
  endtask

  // Compare every output against a set of expected item counts and pulses.
  task automatic check_state(input string tag, input int c [4], input logic [3:0] uok, input logic rej);
    logic [N*CW-1:0] ec;
    logic [N-1:0]    eh;
    int              et;
    ec = '0; eh = '0; et = 0;
    for (int i = 0; i < N; i++) begin
      ec[i*CW +: CW] = CW'(c[i]);
      eh[i]          = (c[i] != 0);
      et            += c[i];
    end
    check({tag, " count"},  32'(count),  32'(ec));
    check({tag, " have"},   32'(have),   32'(eh));
    check({tag, " total"},  32'(total),  32'(et));
    check({tag, " full"},   32'(full),   32'(et == CAP));
    check({tag, " use_ok"}, 32'(use_ok), 32'(uok));
    check({tag, " reject"}, 32'(reject), 32'(rej));
  endtask

  task automatic drive(input logic rst, input logic drop, input logic [3:0] pk, input logic [3:0] us);
    reset = rst; drop_all = drop; pickup = pk; use_req = us;
    @(posedge clk);
    #1;
  endtask

  int m_cnt [4];

  initial begin
    reset = 1'b1; drop_all = 1'b0; pickup = '0; use_req = '0;

    // reset with pickup/use activity
    add(1, 0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0);
    add(1, 0, 4'hA, 4'h5, 0, 0, 0, 0, 4'h0, 0);
    // sticky item 0
    add(0, 0, 4'h1, 4'h0, 1, 0, 0, 0, 4'h0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 4'h0, 4'h1, 1, 0, 0, 0, 4'h1, 0);
    add(0, 0, 4'h1, 4'h1, 2, 0, 0, 0, 4'h1, 0);
    // consumable item 1
    add(0, 0, 4'h2, 4'h0, 2, 1, 0, 0, 4'h0, 0);
    add(0, 0, 4'h2, 4'h0, 2, 2, 0, 0, 4'h0, 0);
    add(0, 0, 4'h0, 4'h2, 2, 1, 0, 0, 4'h2, 0);
    add(0, 0, 4'h0, 4'h2, 2, 0, 0, 0, 4'h2, 0);
    add(0, 0, 4'h0, 4'h2, 2, 0, 0, 0, 4'h0, 0);
    // fill to 7 then a four-way pickup: only item 0 fits
    for (int k = 1; k <= 5; k++) add(0, 0, 4'h4, 4'h0, 2, 0, k, 0, 4'h0, 0);
    add(0, 0, 4'hF, 4'h0, 3, 0, 5, 0, 4'h0, 1);
    add(0, 0, 4'h0, 4'h0, 3, 0, 5, 0, 4'h0, 0);
    add(0, 0, 4'h0, 4'h4, 3, 0, 5, 0, 4'h4, 0);
    add(0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0);
    // consumable pickup+use in the same cycle
    add(0, 0, 4'h2, 4'h0, 0, 1, 0, 0, 4'h0, 0);
    add(0, 0, 4'h2, 4'h2, 0, 1, 0, 0, 4'h2, 0);
    add(0, 0, 4'h0, 4'h2, 0, 0, 0, 0, 4'h2, 0);
    add(0, 0, 4'h2, 4'h2, 0, 1, 0, 0, 4'h0, 0);
    // per-item saturation on item 3, then drop_all over a pickup
    add(0, 1, 4'h8, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    for (int k = 1; k <= MAXC; k++) add(0, 0, 4'h8, 4'h0, 0, 0, 0, k, 4'h0, 0);
    add(0, 0, 4'h8, 4'h0, 0, 0, 0, 7, 4'h0, 1);
    add(0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0);
    // reset discards a concurrent pickup
    add(0, 0, 4'h1, 4'h0, 1, 0, 0, 0, 4'h0, 0);
    add(1, 0, 4'h1, 4'h1, 0, 0, 0, 0, 4'h0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].drop, vecs[k].pk, vecs[k].us);
      check_state($sformatf("vec%0d", k), vecs[k].c, vecs[k].uok, vecs[k].rej);
    end

    // Randomized traffic against an integer model of the inventory rules.
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    for (int t = 0; t < 600; t++) begin
      logic       r_rst, r_drop;
      logic [3:0] r_pk, r_us, e_uok;
      logic       e_rej;
      int         budget;
      int         nxt [4];
      r_rst  = ($urandom_range(0, 79) == 0);
      r_drop = ($urandom_range(0, 39) == 0);
      r_pk   = 4'($urandom) & 4'($urandom | $urandom);
      r_us   = 4'($urandom) & 4'($urandom);
      e_uok  = '0;
      e_rej  = 1'b0;
      if (r_rst || r_drop) begin
        for (int i = 0; i < N; i++) nxt[i] = 0;
      end else begin
        budget = CAP - (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]);
        for (int i = 0; i < N; i++) begin
          nxt[i] = m_cnt[i];
          if (r_pk[i]) begin
            if (m_cnt[i] < MAXC && budget > 0) begin
              nxt[i]++;
              budget--;
            end else begin
              e_rej = 1'b1;
            end
          end
          if (r_us[i] && m_cnt[i] > 0) begin
            e_uok[i] = 1'b1;
            if (MASK[i]) nxt[i]--;
          end
        end
      end
      drive(r_rst, r_drop, r_pk, r_us);
      for (int i = 0; i < N; i++) m_cnt[i] = nxt[i];
      check_state($sformatf("rnd%0d", t), m_cnt, e_uok, e_rej);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
